// File: rtl/usb_status_regfile.sv
// USB GPI status register file: capture, sticky events, irq mask, connect count.
// Optional USB_STATUS_TIMESTAMP_EN adds a free-running timestamp and TSWRAP event.
module usb_status_regfile #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gpi_value,
  input  logic              gpi_valid,
  input  logic              cable_connected,
  input  logic [2:0]        reg_addr,
  input  logic              reg_wr,
  input  logic [DATA_W-1:0] reg_wdata,
  input  logic              reg_rd,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              reg_rvalid,
  output logic              irq
);

`ifdef USB_STATUS_TIMESTAMP_EN
  localparam logic [4:0] EVT_MASK = 5'h1f;
`else
  localparam logic [4:0] EVT_MASK = 5'h0f;
`endif

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_EVENTS = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_COUNT  = 3'd3;
  localparam logic [2:0] A_TS     = 3'd4;

  logic              cable_prev_q, cable_prev_d;
  logic              cap_value_q, cap_value_d;
  logic              cap_valid_q, cap_valid_d;
  logic [4:0]        events_q, events_d;
  logic [4:0]        mask_q, mask_d;
  logic [CNT_W-1:0]  conn_cnt_q, conn_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              irq_q, irq_d;

  logic              connect_evt;
  logic              disconnect_evt;
  logic              wr_events;
  logic              wr_mask;
  logic              wr_count;
  logic [4:0]        evt_clr;
  logic [4:0]        evt_set;
  logic              ovr_set;
  logic [DATA_W-1:0] rd_mux;
  logic              ts_wrap;
  logic [DATA_W-1:0] ts_rd;
  logic              unused_wdata;

  assign unused_wdata = ^reg_wdata;

`ifdef USB_STATUS_TIMESTAMP_EN
  logic [DATA_W-1:0] ts_cnt_q, ts_cnt_d;
  logic [DATA_W-1:0] ts_q, ts_d;

  always_comb begin
    ts_cnt_d = ts_cnt_q + DATA_W'(1);
    ts_d     = gpi_valid ? ts_cnt_q : ts_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      ts_q     <= ts_d;
    end
  end

  assign ts_wrap = &ts_cnt_q;
  assign ts_rd   = ts_q;
`else
  assign ts_wrap = 1'b0;
  assign ts_rd   = '0;
`endif

  assign connect_evt    = cable_connected & ~cable_prev_q;
  assign disconnect_evt = ~cable_connected & cable_prev_q;

  assign wr_events = reg_wr & (reg_addr == A_EVENTS);
  assign wr_mask   = reg_wr & (reg_addr == A_MASK);
  assign wr_count  = reg_wr & (reg_addr == A_COUNT);

  // OVR only counts a capture that lands on a CAP nobody is acknowledging
  assign evt_clr = wr_events ? (reg_wdata[4:0] & EVT_MASK) : 5'h0;
  assign ovr_set = gpi_valid & events_q[2] & ~evt_clr[2];
  assign evt_set = {ts_wrap, ovr_set, gpi_valid,
                    disconnect_evt, connect_evt};

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      A_STATUS: rd_mux[2:0] = {cap_valid_q, cable_prev_q,
                               cap_value_q};
      A_EVENTS: rd_mux[4:0] = events_q;
      A_MASK:   rd_mux[4:0] = mask_q;
      A_COUNT:  rd_mux[CNT_W-1:0] = conn_cnt_q;
      A_TS:     rd_mux = ts_rd;
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    cable_prev_d = cable_connected;
    cap_value_d  = gpi_valid ? gpi_value : cap_value_q;
    cap_valid_d  = cap_valid_q;
    if (gpi_valid)
      cap_valid_d = 1'b1;
    else if (disconnect_evt)
      cap_valid_d = 1'b0;

    events_d = ((events_q & ~evt_clr) | evt_set) & EVT_MASK;
    mask_d   = wr_mask ? (reg_wdata[4:0] & EVT_MASK) : mask_q;

    // a clear racing a connect edge leaves that edge counted
    conn_cnt_d = conn_cnt_q;
    if (wr_count)
      conn_cnt_d = connect_evt ? CNT_W'(1) : '0;
    else if (connect_evt && (conn_cnt_q != '1))
      conn_cnt_d = conn_cnt_q + CNT_W'(1);

    rdata_d  = reg_rd ? rd_mux : '0;
    rvalid_d = reg_rd;
    irq_d    = |(events_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cable_prev_q <= 1'b0;
      cap_value_q  <= 1'b0;
      cap_valid_q  <= 1'b0;
      events_q     <= '0;
      mask_q       <= '0;
      conn_cnt_q   <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      cable_prev_q <= cable_prev_d;
      cap_value_q  <= cap_value_d;
      cap_valid_q  <= cap_valid_d;
      events_q     <= events_d;
      mask_q       <= mask_d;
      conn_cnt_q   <= conn_cnt_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      irq_q        <= irq_d;
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_usb_status_regfile.sv
// Scoreboard bench for usb_status_regfile.
// Reads are predicted at issue time and checked when reg_rvalid appears.
module tb_usb_status_regfile;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
`ifdef USB_STATUS_TIMESTAMP_EN
  localparam bit TS = 1'b1;
`else
  localparam bit TS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              gpi_value = 1'b0;
  logic              gpi_valid = 1'b0;
  logic              cable_connected = 1'b0;
  logic [2:0]        reg_addr = '0;
  logic              reg_wr = 1'b0;
  logic [DATA_W-1:0] reg_wdata = '0;
  logic              reg_rd = 1'b0;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_rvalid;
  logic              irq;

  always #5 clk = ~clk;

  usb_status_regfile #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .gpi_value(gpi_value), .gpi_valid(gpi_valid),
    .cable_connected(cable_connected),
    .reg_addr(reg_addr), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
    .irq(irq)
  );

  typedef struct {
    logic [2:0]        addr;
    logic [DATA_W-1:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  bit m_prev, m_cval, m_cvalid, m_irq;
  int m_evt, m_mask, m_cnt, m_ts, m_tscnt;
  bit use_const = 1'b0;
  logic [DATA_W-1:0] const_val = '0;

  task automatic chk(input string name,
                     input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return DATA_W'({m_cvalid, m_prev, m_cval});
      3'd1: return DATA_W'(m_evt);
      3'd2: return DATA_W'(m_mask);
      3'd3: return DATA_W'(m_cnt);
      3'd4: return TS ? DATA_W'(m_ts) : '0;
      default: return '0;
    endcase
  endfunction

  task automatic model_step();
    bit conn, disc, ovr, wrap;
    int clr, set_b;
    if (reset) begin
      m_prev = 0; m_cval = 0; m_cvalid = 0; m_irq = 0;
      m_evt = 0; m_mask = 0; m_cnt = 0; m_ts = 0; m_tscnt = 0;
      return;
    end
    conn = cable_connected && !m_prev;
    disc = !cable_connected && m_prev;
    clr = (reg_wr && reg_addr == 3'd1) ? (int'(reg_wdata) & 'h1f) : 0;
    if (!TS) clr = clr & 'hf;
    ovr = gpi_valid && m_evt[2] && !clr[2];
    wrap = TS && (m_tscnt == (1 << DATA_W) - 1);
    set_b = 0;
    if (conn) set_b |= 1;
    if (disc) set_b |= 2;
    if (gpi_valid) set_b |= 4;
    if (ovr) set_b |= 8;
    if (wrap) set_b |= 16;
    m_irq = (m_evt & m_mask) != 0;
    m_evt = (m_evt & ~clr) | set_b;
    if (reg_wr && reg_addr == 3'd2)
      m_mask = int'(reg_wdata) & (TS ? 'h1f : 'hf);
    if (reg_wr && reg_addr == 3'd3)
      m_cnt = conn ? 1 : 0;
    else if (conn && m_cnt < (1 << CNT_W) - 1)
      m_cnt++;
    if (gpi_valid) begin
      m_cval = gpi_value;
      m_ts = m_tscnt;
      m_cvalid = 1;
    end else if (disc) begin
      m_cvalid = 0;
    end
    m_tscnt = (m_tscnt + 1) % (1 << DATA_W);
    m_prev = cable_connected;
  endtask

  task automatic cycle();
    exp_t e;
    if (reg_rd) begin
      e.addr = reg_addr;
      e.val = use_const ? const_val : model_read(reg_addr);
      sb.push_back(e);
    end
    model_step();
    @(posedge clk);
    #1;
    chk("irq", DATA_W'(irq), DATA_W'(m_irq));
    gpi_valid = 1'b0;
    reg_wr = 1'b0;
    reg_rd = 1'b0;
    use_const = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic rd_c(input logic [2:0] a, input logic [DATA_W-1:0] v);
    reg_addr = a; reg_rd = 1'b1;
    use_const = 1'b1; const_val = v;
    cycle();
  endtask

  task automatic rd_m(input logic [2:0] a);
    reg_addr = a; reg_rd = 1'b1;
    cycle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [DATA_W-1:0] d);
    reg_addr = a; reg_wr = 1'b1; reg_wdata = d;
    cycle();
  endtask

  task automatic pulse(input logic v);
    gpi_valid = 1'b1; gpi_value = v;
    cycle();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reg_rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_extra: got rvalid=1 with data %h, expected no read", reg_rdata);
      end else begin
        e = sb.pop_front();
        chk($sformatf("read_addr%0d", e.addr), reg_rdata, e.val);
      end
    end else if (!reset) begin
      chk("rdata_idle", reg_rdata, '0);
    end
  end

  initial begin
    reset = 1'b1;
    idle(3);
    reset = 1'b0;

    for (int a = 0; a < 4; a++) begin
      rd_c(3'(a), '0);
      idle(1);
    end

    cable_connected = 1'b1;
    idle(1);
    pulse(1'b1);
    rd_c(3'd0, 'h7);
    rd_c(3'd1, 'h5);
    rd_c(3'd3, 'h1);
    cable_connected = 1'b0;
    idle(1);
    rd_c(3'd0, 'h1);
    rd_c(3'd1, 'h7);
    wr(3'd1, 'h1f);
    rd_c(3'd1, 'h0);

    wr(3'd2, 'h4);
    pulse(1'b0);
    chk("irq_pre", DATA_W'(irq), '0);
    idle(1);
    chk("irq_set", DATA_W'(irq), DATA_W'(1));
    wr(3'd1, 'h4);
    chk("irq_hold", DATA_W'(irq), DATA_W'(1));
    idle(1);
    chk("irq_clr", DATA_W'(irq), '0);
    pulse(1'b0);
    pulse(1'b0);
    rd_c(3'd1, 'hc);
    rd_c(3'd0, 'h4);

    wr(3'd1, 'h1f);
    pulse(1'b1);
    gpi_valid = 1'b1;
    gpi_value = 1'b1;
    wr(3'd1, 'h4);
    rd_c(3'd1, 'h4);
    rd_c(3'd0, 'h5);

    reg_wr = 1'b1;
    reg_wdata = 'h3;
    rd_c(3'd2, 'h4);
    rd_c(3'd2, 'h3);

    wr(3'd5, '1);
    wr(3'd7, '1);
    rd_c(3'd5, '0);
    rd_c(3'd6, '0);
    rd_c(3'd7, '0);
`ifdef USB_STATUS_TIMESTAMP_EN
    rd_m(3'd4);
`else
    rd_c(3'd4, '0);
`endif

    wr(3'd3, '0);
    rd_c(3'd3, '0);
    repeat (300) begin
      cable_connected = 1'b1;
      idle(1);
      cable_connected = 1'b0;
      idle(1);
    end
    rd_c(3'd3, 'hff);
    wr(3'd3, '0);
    rd_c(3'd3, '0);
    cable_connected = 1'b1;
    wr(3'd3, '0);
    rd_c(3'd3, 'h1);
    cable_connected = 1'b0;
    idle(1);

    cable_connected = 1'b1;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    rd_c(3'd3, 'h1);
    rd_c(3'd1, 'h1);
    rd_c(3'd0, 'h2);

    repeat (1500) begin
      if ($urandom_range(9) == 0)
        cable_connected = ~cable_connected;
      gpi_valid = ($urandom_range(3) == 0);
      gpi_value = 1'($urandom);
      reg_addr = 3'($urandom_range(7));
      if ($urandom_range(6) == 0) begin
        reg_wr = 1'b1;
        reg_wdata = DATA_W'($urandom);
      end
      reg_rd = 1'($urandom);
      cycle();
    end

`ifdef USB_STATUS_TIMESTAMP_EN
    cable_connected = 1'b0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(99);
    pulse(1'b1);
    rd_m(3'd4);
    idle(1 << DATA_W);
    rd_m(3'd1);
    rd_m(3'd4);
`endif

    idle(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d reads pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_status_regfile.md
Name: usb_status_regfile

Overview:
Consumer stage for the USB GPI status monitor. Captures the GPI value on each one-cycle valid pulse and tracks cable connect/disconnect. Exposes status, sticky events, an interrupt mask and a connect counter to the control CPU through a simple single-cycle register bus. Drives one level interrupt line.

Parameters:
DATA_W, 16, register bus data width; minimum 8.
CNT_W, 8, connect counter width; must satisfy CNT_W <= DATA_W.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  reset, synchronous, active-high.
gpi_value  in  1  GPI status level from the monitor; sampled only when gpi_valid=1.
gpi_valid  in  1  one-cycle capture strobe from the monitor.
cable_connected  in  1  connection level from the monitor; 1 means connected.
reg_addr  in  3  register address.
reg_wr  in  1  write strobe.
reg_wdata  in  DATA_W  write data.
reg_rd  in  1  read strobe.
reg_rdata  out  DATA_W  read data; valid when reg_rvalid=1.
reg_rvalid  out  1  one-cycle read acknowledge.
irq  out  1  interrupt, registered level.

Behaviour:
- Reset: all registers, reg_rdata, reg_rvalid, irq and the internal previous-cable flop are 0.
- Edge detect: cable_prev follows cable_connected one cycle later. connect_evt = cable_connected & ~cable_prev. disconnect_evt = ~cable_connected & cable_prev.
- Register map. Unused bits read 0.
  - 0x0 STATUS (RO):
    - bit0 cap_value: loaded with gpi_value when gpi_valid=1.
    - bit1 cable_connected: delayed copy (cable_prev).
    - bit2 cap_valid: set on gpi_valid, cleared on disconnect_evt. If both occur in the same cycle, set wins.
  - 0x1 EVENTS (sticky, write-1-to-clear):
    - bit0 CONN: set on connect_evt.
    - bit1 DISC: set on disconnect_evt.
    - bit2 CAP: set on gpi_valid.
    - bit3 OVR: set on gpi_valid while CAP is already 1 and CAP is not being cleared in the same cycle.
    - A set and a W1C on the same bit in the same cycle: set wins.
  - 0x2 IRQ_MASK (RW, bits[3:0]): one enable per EVENTS bit.
  - 0x3 CONN_COUNT (RO, CNT_W bits): increments on connect_evt, saturates at all-ones. Any write to 0x3 clears it. A clear and an increment in the same cycle give 1.
  - 0x4 TIMESTAMP: optional, see below. Reads 0 when not built.
  - 0x5 to 0x7: reads return 0; writes are ignored.
- Read: reg_rd=1 in cycle N gives reg_rdata and reg_rvalid=1 in cycle N+1. Read data reflects register contents before any same-cycle update. reg_rdata returns to 0 when reg_rvalid=0.
- Simultaneous reg_rd and reg_wr to the same address: the read returns the old value, and the write takes effect.
- irq is registered from |(EVENTS & IRQ_MASK) of the current cycle, so it asserts one cycle after the event flop sets.
- gpi_valid while cable_connected=0 is still captured; no gating.
- Reset mid-operation clears all state. A cable that is already high at reset release produces a connect_evt on the first cycle after reset, because cable_prev resets to 0.

Optional Feature:
USB_STATUS_TIMESTAMP_EN
- Defined:
  - A free-running DATA_W-bit counter increments every cycle from reset and wraps to 0.
  - On gpi_valid its current value is latched into TIMESTAMP (0x4, RO).
  - EVENTS bit4 TSWRAP sets when the free-running counter wraps. It is W1C, and IRQ_MASK bit4 enables it.
- Not defined: no counter is built. 0x4 and EVENTS/IRQ_MASK bit4 read 0.

Test Plan:
1. Reset, then read 0x0–0x3 -> all read 0. irq=0. reg_rvalid is high for exactly one cycle per read.
2. Raise cable_connected, then pulse gpi_valid with gpi_value=1 -> STATUS=0x7, EVENTS=0x5, CONN_COUNT=1. Lower cable_connected -> STATUS=0x1, EVENTS=0x7.
3. Write IRQ_MASK=0x4 and pulse gpi_valid -> irq=1 two cycles after the pulse. Write 0x4 to EVENTS -> irq=0 one cycle after the write. A second gpi_valid pulse without clearing CAP -> OVR set.
4. Issue the EVENTS W1C on the same cycle as a gpi_valid pulse -> CAP remains 1.
5. Toggle cable_connected 300 times (CNT_W=8) -> CONN_COUNT=255. Write 0x3 -> 0. Write 0x3 on the same cycle as a connect edge -> 1.
6. With USB_STATUS_TIMESTAMP_EN defined, pulse gpi_valid at cycle 100 after reset -> TIMESTAMP equals the counter value at that edge (99 or 100 per the counter's reset cycle; the bench checks against the model). Run 2^DATA_W cycles -> EVENTS bit4 set.
